// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO result controller.
// Watchdog sizing is only used when HILO_TIMEOUT_EN is defined.
package hilo_pkg;

  localparam int HILO_WIDTH         = 32;
  localparam int HILO_TIMEOUT_LIMIT = 48;
  localparam int HILO_WD_WIDTH      = 6;

  typedef logic [HILO_WIDTH-1:0] hilo_word_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MULT_WAIT = 2'd1,
    DIV_WAIT  = 2'd2
  } hilo_state_e;

endpackage

// File: rtl/hilo_if.sv
// Bundle of control, multiplier, divider and HI/LO access signals.
// The slave modport is the controller's view; master is its environment.
interface hilo_if;
  import hilo_pkg::*;

  logic       mult_req;
  logic       div_req;
  logic       mult_start;
  logic       div_start;

  hilo_word_t mult_hi;
  hilo_word_t mult_lo;
  logic       mult_done;

  hilo_word_t div_hi;
  hilo_word_t div_lo;
  logic       div_done;
  logic       div_by_zero;

  logic       mthi;
  logic       mtlo;
  hilo_word_t wr_data;

  hilo_word_t hi;
  hilo_word_t lo;
  logic       busy;
  logic       div_zero_exc;
  logic       timeout_err;

  modport slave (
    input  mult_req, div_req,
    input  mult_hi, mult_lo, mult_done,
    input  div_hi, div_lo, div_done, div_by_zero,
    input  mthi, mtlo, wr_data,
    output mult_start, div_start,
    output hi, lo, busy, div_zero_exc, timeout_err
  );

  modport master (
    output mult_req, div_req,
    output mult_hi, mult_lo, mult_done,
    output div_hi, div_lo, div_done, div_by_zero,
    output mthi, mtlo, wr_data,
    input  mult_start, div_start,
    input  hi, lo, busy, div_zero_exc, timeout_err
  );

endinterface

// File: rtl/hilo_watchdog.sv
// Wait-state cycle counter; instantiated only when HILO_TIMEOUT_EN is defined.
// expired is high during the last permitted wait cycle (count == limit-1).
module hilo_watchdog
  import hilo_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [HILO_WD_WIDTH-1:0] LAST_COUNT = HILO_WD_WIDTH'(HILO_TIMEOUT_LIMIT - 1);

  logic [HILO_WD_WIDTH-1:0] count_q;
  logic [HILO_WD_WIDTH-1:0] count_d;

  // NOTE: count_d gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && !clear && (count_q == LAST_COUNT);

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO register controller: launches multiply/divide, captures results, handles mthi/mtlo.
// Define HILO_TIMEOUT_EN to add a watchdog that abandons a wait after HILO_TIMEOUT_LIMIT cycles.
module hilo_ctrl
  import hilo_pkg::*;
(
  input logic   clock,
  input logic   reset,
  hilo_if.slave bus
);

  hilo_state_e state_q;
  hilo_word_t  hi_q;
  hilo_word_t  lo_q;
  logic        busy_q;
  logic        mult_start_q;
  logic        div_start_q;
  logic        div_zero_exc_q;
  logic        wd_expired;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      busy_q         <= 1'b0;
      mult_start_q   <= 1'b0;
      div_start_q    <= 1'b0;
      div_zero_exc_q <= 1'b0;
      hi_q           <= '0;
      lo_q           <= '0;
    end else begin
      mult_start_q   <= 1'b0;
      div_start_q    <= 1'b0;
      div_zero_exc_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // A direct write and a request in the same cycle both take effect.
          if (bus.mthi) hi_q <= bus.wr_data;
          if (bus.mtlo) lo_q <= bus.wr_data;
          if (bus.mult_req) begin
            state_q      <= MULT_WAIT;
            busy_q       <= 1'b1;
            mult_start_q <= 1'b1;
          end else if (bus.div_req) begin
            state_q     <= DIV_WAIT;
            busy_q      <= 1'b1;
            div_start_q <= 1'b1;
          end
        end
        MULT_WAIT: begin
          if (bus.mult_done) begin
            hi_q    <= bus.mult_hi;
            lo_q    <= bus.mult_lo;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (wd_expired) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        DIV_WAIT: begin
          if (bus.div_done) begin
            if (bus.div_by_zero) begin
              div_zero_exc_q <= 1'b1;
            end else begin
              hi_q <= bus.div_hi;
              lo_q <= bus.div_lo;
            end
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (wd_expired) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef HILO_TIMEOUT_EN
  logic timeout_err_q;
  logic wait_done;

  // A done arriving on the final watchdog cycle wins over the timeout.
  assign wait_done = ((state_q == MULT_WAIT) && bus.mult_done) ||
                     ((state_q == DIV_WAIT)  && bus.div_done);

  hilo_watchdog u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (state_q == IDLE),
    .enable  (state_q != IDLE),
    .expired (wd_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= wd_expired && !wait_done;
    end
  end

  assign bus.timeout_err = timeout_err_q;
`else
  assign wd_expired      = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.hi           = hi_q;
  assign bus.lo           = lo_q;
  assign bus.busy         = busy_q;
  assign bus.mult_start   = mult_start_q;
  assign bus.div_start    = div_start_q;
  assign bus.div_zero_exc = div_zero_exc_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Scoreboard bench for hilo_ctrl: a transaction-level model queues per-cycle expectations,
// a monitor pops and compares them on every falling edge.
module tb_hilo_ctrl;

  localparam int LIMIT   = 48;
  localparam int OP_NONE = 0;
  localparam int OP_MUL  = 1;
  localparam int OP_DIV  = 2;
`ifdef HILO_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    logic        busy;
    logic        mult_start;
    logic        div_start;
    logic        div_zero_exc;
    logic        timeout_err;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  hilo_if bus ();

  hilo_ctrl dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  int          m_op   = OP_NONE;
  int          m_wait = 0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  // Effect of the coming rising edge on the architectural view, from the currently driven inputs.
  task automatic model_step();
    exp_t e;
    e.mult_start   = 1'b0;
    e.div_start    = 1'b0;
    e.div_zero_exc = 1'b0;
    e.timeout_err  = 1'b0;
    if (rst) begin
      m_op = OP_NONE;
      m_hi = '0;
      m_lo = '0;
    end else if (m_op == OP_NONE) begin
      if (bus.mthi) m_hi = bus.wr_data;
      if (bus.mtlo) m_lo = bus.wr_data;
      if (bus.mult_req) begin
        m_op = OP_MUL; m_wait = 0; e.mult_start = 1'b1;
      end else if (bus.div_req) begin
        m_op = OP_DIV; m_wait = 0; e.div_start = 1'b1;
      end
    end else begin
      m_wait++;
      if (m_op == OP_MUL && bus.mult_done) begin
        m_hi = bus.mult_hi; m_lo = bus.mult_lo; m_op = OP_NONE;
      end else if (m_op == OP_DIV && bus.div_done) begin
        if (bus.div_by_zero) e.div_zero_exc = 1'b1;
        else begin m_hi = bus.div_hi; m_lo = bus.div_lo; end
        m_op = OP_NONE;
      end else if (TO_EN && m_wait == LIMIT) begin
        e.timeout_err = 1'b1;
        m_op = OP_NONE;
      end
    end
    e.busy = (m_op != OP_NONE);
    e.hi   = m_hi;
    e.lo   = m_lo;
    exp_q.push_back(e);
  endtask

  task automatic clear_inputs();
    rst             = 1'b0;
    bus.mult_req    = 1'b0;
    bus.div_req     = 1'b0;
    bus.mult_done   = 1'b0;
    bus.div_done    = 1'b0;
    bus.div_by_zero = 1'b0;
    bus.mthi        = 1'b0;
    bus.mtlo        = 1'b0;
    bus.wr_data     = $urandom();
    bus.mult_hi     = $urandom();
    bus.mult_lo     = $urandom();
    bus.div_hi      = $urandom();
    bus.div_lo      = $urandom();
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Monitor: one expectation per clock, compared away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty at %0t: got no expectation, expected one per cycle", $time);
      end else begin
        e = exp_q.pop_front();
        check("busy",         bus.busy,         e.busy);
        check("mult_start",   bus.mult_start,   e.mult_start);
        check("div_start",    bus.div_start,    e.div_start);
        check("div_zero_exc", bus.div_zero_exc, e.div_zero_exc);
        check("timeout_err",  bus.timeout_err,  e.timeout_err);
        check("hi",           bus.hi,           e.hi);
        check("lo",           bus.lo,           e.lo);
      end
    end
  end

  initial begin
    clear_inputs();
    rst = 1'b1; tick();
    rst = 1'b1; tick();
    idle(2);

    // Direct writes in IDLE.
    bus.mthi = 1'b1; bus.wr_data = 32'hDEAD_BEEF; tick();
    idle(1);
    bus.mtlo = 1'b1; bus.wr_data = 32'h1234_5678; tick();

    // Multiply completing 33 cycles after the request, with noise while busy.
    bus.mult_req = 1'b1; tick();
    for (int i = 1; i < 33; i++) begin
      case (i)
        5:       bus.mtlo     = 1'b1;
        7:       bus.mult_req = 1'b1;
        9:       bus.div_req  = 1'b1;
        11:      bus.div_done = 1'b1;
        13:      begin bus.mthi = 1'b1; bus.mtlo = 1'b1; end
        default: ;
      endcase
      tick();
    end
    bus.mult_done = 1'b1; bus.mult_hi = 32'h0000_0001; bus.mult_lo = 32'hFFFF_FFFE; tick();
    idle(2);

    // Divide with a result, then divide by zero.
    bus.div_req = 1'b1; tick();
    idle(2);
    bus.mult_done = 1'b1; tick();
    idle(2);
    bus.div_done = 1'b1; bus.div_hi = 32'd3; bus.div_lo = 32'd14; tick();
    idle(1);
    bus.div_req = 1'b1; tick();
    idle(3);
    bus.div_done = 1'b1; bus.div_by_zero = 1'b1; tick();
    idle(2);

    // Simultaneous requests plus a write; multiply wins, second request ignored.
    bus.mult_req = 1'b1; bus.div_req = 1'b1; bus.mthi = 1'b1; tick();
    idle(2);
    bus.mult_req = 1'b1; tick();
    idle(2);
    bus.div_done = 1'b1; tick();
    bus.mult_done = 1'b1; tick();
    idle(1);

    // Reset in the middle of a multiply; the late result must be ignored.
    bus.mult_req = 1'b1; tick();
    idle(9);
    rst = 1'b1; tick();
    bus.mult_done = 1'b1; tick();
    idle(2);

    // Divide left waiting past the watchdog limit.
    bus.div_req = 1'b1; tick();
    idle(LIMIT + 10);
    bus.div_done = 1'b1; tick();
    idle(2);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      rst             = ($urandom_range(63) == 0);
      bus.mult_req    = ($urandom_range(7) == 0);
      bus.div_req     = ($urandom_range(7) == 0);
      bus.mult_done   = ($urandom_range(9) == 0);
      bus.div_done    = ($urandom_range(9) == 0);
      bus.div_by_zero = ($urandom_range(1) == 1);
      bus.mthi        = ($urandom_range(5) == 0);
      bus.mtlo        = ($urandom_range(5) == 0);
      tick();
    end
    idle(2);

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_ctrl.md
HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 Port clock: input, 1 bit; sole clock, all state updates on its rising edge.
REQ-002 Port reset: input, 1 bit; synchronous, active-high reset.
REQ-003 Ports mult_req, div_req: inputs, 1 bit each; one-cycle requests from the main control unit.
REQ-004 Port mult_start: output, 1 bit; one-cycle start pulse to the Booth multiplier.
REQ-005 Port div_start: output, 1 bit; one-cycle start pulse to the divider.
REQ-006 Ports mult_hi, mult_lo: inputs, 32 bits each; multiplier result; mult_done: input, 1 bit; multiplier result valid.
REQ-007 Ports div_hi, div_lo: inputs, 32 bits each (remainder, quotient); div_done: input, 1 bit; div_by_zero: input, 1 bit, qualified by div_done.
REQ-008 Ports mthi, mtlo: inputs, 1 bit each; wr_data: input, 32 bits; direct HI/LO write.
REQ-009 Ports hi, lo: outputs, 32 bits each; architectural HI/LO registers (mfhi/mflo source).
REQ-010 Port busy: output, 1 bit; high while an operation is outstanding, used by control to stall mfhi/mflo/mult/div.
REQ-011 Ports div_zero_exc, timeout_err: outputs, 1 bit each; one-cycle error pulses.

Function
REQ-012 FSM states SHALL be IDLE, MULT_WAIT, DIV_WAIT; busy SHALL equal (state != IDLE), registered.
REQ-013 In IDLE, mult_req SHALL set mult_start=1 for exactly the next cycle and move to MULT_WAIT at the same edge.
REQ-014 In IDLE, div_req SHALL set div_start=1 for exactly the next cycle and move to DIV_WAIT at the same edge.
REQ-015 mult_req and div_req both high in IDLE: multiply accepted, divide dropped.
REQ-016 mult_req/div_req while busy SHALL be ignored; no start pulse issued.
REQ-017 MULT_WAIT: on the edge sampling mult_done=1, hi<=mult_hi, lo<=mult_lo, state<=IDLE; busy low the following cycle.
REQ-018 DIV_WAIT: on the edge sampling div_done=1 with div_by_zero=0, hi<=div_hi, lo<=div_lo, state<=IDLE.
REQ-019 DIV_WAIT with div_done=1 and div_by_zero=1: hi/lo unchanged, div_zero_exc=1 for one cycle, state<=IDLE.
REQ-020 mult_done in DIV_WAIT or div_done in MULT_WAIT/IDLE SHALL be ignored.
REQ-021 mthi/mtlo SHALL write wr_data to hi/lo only in IDLE; ignored while busy.
REQ-022 mthi and mtlo together in IDLE SHALL write both registers with wr_data.
REQ-023 mthi/mtlo in the same IDLE cycle as a request: write takes effect and request accepted; later result overwrites.
REQ-024 hi/lo SHALL change only per REQ-017/018/021/022/026.

Reset
REQ-025 reset=1 at a rising edge SHALL force state=IDLE, busy=0, mult_start=0, div_start=0, div_zero_exc=0, timeout_err=0, watchdog count=0.
REQ-026 reset SHALL clear hi and lo to 32'd0.
REQ-027 reset mid-operation SHALL abandon the operation; a subsequent mult_done/div_done SHALL be ignored.

Configuration
REQ-028 Macro HILO_TIMEOUT_EN defined: 6-bit watchdog counts cycles in MULT_WAIT/DIV_WAIT, cleared on entry; reaching HILO_TIMEOUT_LIMIT (48) without done SHALL pulse timeout_err one cycle, return to IDLE, leave hi/lo unchanged.
REQ-029 Macro undefined: no watchdog logic; timeout_err tied to 0; wait states held until done.

Structure
REQ-030 Package hilo_pkg SHALL hold the state enum (IDLE, MULT_WAIT, DIV_WAIT), HILO_WIDTH=32 and HILO_TIMEOUT_LIMIT=48.
REQ-031 Watchdog SHALL be sub-module hilo_watchdog (clear, enable, expired), instantiated only under HILO_TIMEOUT_EN.

Verification
REQ-032 mult_req, then mult_done 33 cycles later with mult_hi=32'h0000_0001, mult_lo=32'hFFFF_FFFE -> one mult_start pulse, busy high throughout, hi/lo equal those values, busy low next cycle.
REQ-033 div_req, div_done with div_hi=32'd3, div_lo=32'd14 -> hi=3, lo=14; div_by_zero case -> hi/lo unchanged, one div_zero_exc pulse.
REQ-034 mult_req and div_req same IDLE cycle -> only mult_start pulses, state MULT_WAIT; second mult_req while busy -> no pulse.
REQ-035 mthi wr_data=32'hDEAD_BEEF in IDLE -> hi=32'hDEAD_BEEF; mtlo while busy -> lo unchanged.
REQ-036 reset at cycle 10 of MULT_WAIT, then mult_done -> hi=lo=0, busy=0, result ignored.
REQ-037 HILO_TIMEOUT_EN, no div_done for 48 cycles -> timeout_err pulse, busy low, hi/lo unchanged; undefined -> busy stays high.
